// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity selection codes,
// used by both the transmitter and the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Code 2'b11 is treated as no parity.
  function automatic logic par_enabled(input logic [1:0] sel);
    return (sel == PAR_EVEN) || (sel == PAR_ODD);
  endfunction

  function automatic logic parity_bit(input logic [1:0] sel, input logic data_xor);
    return (sel == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses tick on the last cycle of every CLKS_PER_BIT
// window; held at zero while clear is asserted.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !rst && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, 5..9 data bits LSB first,
// optional even/odd parity and one or two stop bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [1:0]           parity_sel,
  input  logic                 two_stop,
  output logic                 RsTx,
  output logic                 active,
  output logic                 done
);

  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_state_t          state;
  logic [DATA_BITS-1:0] sh;
  logic [IW-1:0]        idx;
  logic                 stop_cnt;
  logic                 par_en_r;
  logic                 par_bit_r;
  logic                 two_r;
  logic                 tick;

  assign tx_ready = (state == IDLE) && !rst;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state == IDLE),
    .tick  (tick)
  );

  // Parity is folded at capture so the shift register can consume the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      RsTx      <= 1'b1;
      active    <= 1'b0;
      done      <= 1'b0;
      sh        <= '0;
      idx       <= '0;
      stop_cnt  <= 1'b0;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      two_r     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          RsTx <= 1'b1;
          if (tx_valid) begin
            sh        <= tx_data;
            par_en_r  <= par_enabled(parity_sel);
            par_bit_r <= parity_bit(parity_sel, ^tx_data);
            two_r     <= two_stop;
            idx       <= '0;
            stop_cnt  <= 1'b0;
            active    <= 1'b1;
            RsTx      <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (tick) begin
            RsTx  <= sh[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == LAST_IDX) begin
              if (par_en_r) begin
                RsTx  <= par_bit_r;
                state <= PARITY;
              end else begin
                RsTx  <= 1'b1;
                state <= STOP;
              end
            end else begin
              RsTx <= sh[1];
              sh   <= sh >> 1;
              idx  <= idx + IW'(1);
            end
          end
        end
        PARITY: begin
          if (tick) begin
            RsTx  <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          RsTx <= 1'b1;
          if (tick) begin
            if (stop_cnt == two_r) begin
              done   <= 1'b1;
              active <= 1'b0;
              state  <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          RsTx   <= 1'b1;
          active <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: expected frames are queued when driven
// and compared against the frame decoded from RsTx when done pulses.
module tb_uart_tx_cfg;

  localparam int CPB = 4;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data8 = '0;
  logic       tx_valid8 = 1'b0;
  logic [1:0] parity_sel8 = '0;
  logic       two_stop8 = 1'b0;
  logic       tx_ready8, RsTx8, active8, done8;
  logic [4:0] tx_data5 = '0;
  logic       tx_valid5 = 1'b0;
  logic [1:0] parity_sel5 = '0;
  logic       two_stop5 = 1'b0;
  logic       tx_ready5, RsTx5, active5, done5;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q8[$];
  exp_t q5[$];

  logic        coll[2];
  int          cnt[2];
  logic [15:0] got[2];
  logic        stable[2];

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .tx_data(tx_data8), .tx_valid(tx_valid8),
    .tx_ready(tx_ready8), .parity_sel(parity_sel8), .two_stop(two_stop8),
    .RsTx(RsTx8), .active(active8), .done(done8)
  );

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5)) dut5 (
    .clk(clk), .rst(rst), .tx_data(tx_data5), .tx_valid(tx_valid5),
    .tx_ready(tx_ready5), .parity_sel(parity_sel5), .two_stop(two_stop5),
    .RsTx(RsTx5), .active(active5), .done(done5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t build_frame(input logic [8:0] d, input int dbits,
                                       input logic [1:0] p, input logic t);
    exp_t f;
    int   n;
    logic x;
    f.bits = '0;
    n = 1;
    x = 1'b0;
    for (int i = 0; i < dbits; i++) begin
      f.bits[n[3:0]] = d[i[3:0]];
      x = x ^ d[i[3:0]];
      n++;
    end
    if (p == 2'b01) begin
      f.bits[n[3:0]] = x;
      n++;
    end else if (p == 2'b10) begin
      f.bits[n[3:0]] = ~x;
      n++;
    end
    f.bits[n[3:0]] = 1'b1;
    n++;
    if (t) begin
      f.bits[n[3:0]] = 1'b1;
      n++;
    end
    f.nbits = n;
    return f;
  endfunction

  // Frame decoder: collects RsTx samples from the start bit until done.
  task automatic mon_step(input int id, input logic line, input logic act, input logic dn);
    exp_t e;
    int   bi;
    if (coll[id]) begin
      if (dn) begin
        coll[id] = 1'b0;
        if ((id == 0 ? q8.size() : q5.size()) == 0) begin
          check("sb_empty", 0, 1);
        end else begin
          e = (id == 0) ? q8.pop_front() : q5.pop_front();
          check(id == 0 ? "len8" : "len5", cnt[id], CPB * e.nbits);
          check(id == 0 ? "bits8" : "bits5", got[id], e.bits);
          check(id == 0 ? "hold8" : "hold5", stable[id], 1);
        end
      end else if (!act) begin
        coll[id] = 1'b0;
      end else begin
        bi = cnt[id] / CPB;
        if (bi < 16) begin
          if (cnt[id] % CPB == 0) got[id][bi[3:0]] = line;
          else if (line !== got[id][bi[3:0]]) stable[id] = 1'b0;
        end
        cnt[id]++;
      end
    end else if (line == 1'b0 && act) begin
      coll[id]   = 1'b1;
      cnt[id]    = 1;
      got[id]    = '0;
      stable[id] = 1'b1;
    end
  endtask

  initial begin
    coll[0] = 1'b0;
    coll[1] = 1'b0;
  end

  always @(negedge clk) begin
    mon_step(0, RsTx8, active8, done8);
    mon_step(1, RsTx5, active5, done5);
  end

  task automatic wait_done(input int id);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(id == 0 ? done8 : done5) && n < 200);
    if (!(id == 0 ? done8 : done5)) check("timeout_done", 0, 1);
  endtask

  task automatic send(input int id, input logic [8:0] d, input logic [1:0] p, input logic t);
    int n = 0;
    while (!(id == 0 ? tx_ready8 : tx_ready5) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(id == 0 ? tx_ready8 : tx_ready5)) check("timeout_ready", 0, 1);
    if (id == 0) begin
      tx_data8 = d[7:0]; parity_sel8 = p; two_stop8 = t; tx_valid8 = 1'b1;
      q8.push_back(build_frame(d, 8, p, t));
    end else begin
      tx_data5 = d[4:0]; parity_sel5 = p; two_stop5 = t; tx_valid5 = 1'b1;
      q5.push_back(build_frame(d, 5, p, t));
    end
    @(negedge clk);
    tx_valid8 = 1'b0;
    tx_valid5 = 1'b0;
    check("ready_busy", id == 0 ? tx_ready8 : tx_ready5, 0);
    check("active_busy", id == 0 ? active8 : active5, 1);
  endtask

  initial begin
    logic [7:0] b2b[3];
    int seen;
    b2b[0] = 8'h3C; b2b[1] = 8'hC3; b2b[2] = 8'h81;

    // Reset state, with a request presented during reset.
    tx_valid8 = 1'b1;
    @(negedge clk);
    check("rst_rstx", RsTx8, 1);
    check("rst_active", active8, 0);
    check("rst_done", done8, 0);
    check("rst_ready", tx_ready8, 0);
    tx_valid8 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_accept", active8, 0);
    check("idle_ready", tx_ready8, 1);

    // Idle line ignores data/config inputs.
    tx_data8 = 8'h00; parity_sel8 = 2'b10; two_stop8 = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_rstx", RsTx8, 1);

    send(0, 9'h0A5, 2'b00, 1'b0);
    wait_done(0);
    @(negedge clk);
    check("done_pulse", done8, 0);

    send(0, 9'h007, 2'b01, 1'b0);
    wait_done(0);
    send(0, 9'h007, 2'b10, 1'b0);
    wait_done(0);

    send(1, 9'h01F, 2'b00, 1'b1);
    wait_done(1);

    // Back-to-back frames with tx_valid held high.
    repeat (2) @(negedge clk);
    tx_data8 = b2b[0]; parity_sel8 = 2'b00; two_stop8 = 1'b0; tx_valid8 = 1'b1;
    q8.push_back(build_frame({1'b0, b2b[0]}, 8, 2'b00, 1'b0));
    for (int f = 0; f < 3; f++) begin
      repeat (10) @(negedge clk);
      check("b2b_ready_low", tx_ready8, 0);
      wait_done(0);
      if (f < 2) begin
        tx_data8 = b2b[f+1];
        q8.push_back(build_frame({1'b0, b2b[f+1]}, 8, 2'b00, 1'b0));
        @(negedge clk);
        check("b2b_gap", RsTx8, 0);
      end else begin
        tx_valid8 = 1'b0;
      end
    end

    // Inputs changed mid-frame must not affect the frame.
    repeat (2) @(negedge clk);
    send(0, 9'h05A, 2'b01, 1'b0);
    tx_data8 = 8'hFF; parity_sel8 = 2'b10; two_stop8 = 1'b1;
    wait_done(0);

    // Reset during DATA aborts the frame with no done.
    repeat (2) @(negedge clk);
    send(0, 9'h096, 2'b00, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rstx", RsTx8, 1);
    check("abort_active", active8, 0);
    check("abort_ready", tx_ready8, 0);
    rst = 1'b0;
    void'(q8.pop_back());
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done8) seen++;
    end
    check("abort_no_done", seen, 0);

    send(0, 9'h069, 2'b10, 1'b1);
    wait_done(0);

    repeat (4) @(negedge clk);
    check("sb_drain8", q8.size(), 0);
    check("sb_drain5", q5.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
